axi_alu_initiator: RTL and testbench
====================================

Name: axi_alu_initiator

Overview:
- Initiator/master side of the byte-wide FIFO channel pair in the AXI ALU path.
- Accepts one ALU command (opcode, operand A, operand B) from local logic.
- Serialises the command as three bytes onto the FIFO write data channel.
- Then requests and collects the 9-bit result (8-bit value plus carry) from the FIFO read data channel and returns it to local logic.

Parameters:
TIMEOUT, 1024, max cycles in WAIT_RES without a read handshake before abort; 0 disables timeout
CNT_W, 16, width of timeout counter and transaction counter

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  local command request
cmd_ready  output  1  initiator idle, command accepted when cmd_valid && cmd_ready
cmd_op  input  3  ALU opcode
cmd_a  input  8  operand A
cmd_b  input  8  operand B
wdata  output  8  write data channel byte
wvalid  output  1  write byte valid
wready  input  1  FIFO not full
rvalid  output  1  read request to FIFO
rready  input  1  FIFO not empty
rdata  input  9  FIFO read data, registered by FIFO one cycle after read handshake
res_valid  output  1  one-cycle pulse, result available
res_data  output  9  result {carry, value}
res_err  output  1  one-cycle pulse with res_valid on timeout
busy  output  1  high in every state except IDLE
txn_count  output  CNT_W  completed transactions, including timeouts

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; wvalid=0; wdata=0; rvalid=0; res_valid=0; res_data=0; res_err=0; busy=0; txn_count=0; timeout counter=0.
- Reset mid-transaction: abort immediately; no partial result is reported; bytes already accepted by the FIFO are not recalled.
- States: IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RES, CAPTURE.
- IDLE: cmd_ready=1. On cmd_valid, latch op/a/b and go to SEND_OP. wvalid rises the next cycle.
- SEND_OP/SEND_A/SEND_B:
  - wvalid=1.
  - wdata = {5'b0, op}, then a, then b, each driven from the latched registers.
  - A beat transfers on a cycle with wvalid && wready; the state then advances.
  - wvalid and wdata are held stable while wready=0.
  - wvalid stays continuous across beats when wready stays high: 3 beats in 3 cycles minimum.
- After the B beat, go to WAIT_RES. rvalid=1 and the timeout counter is cleared on entry.
- WAIT_RES:
  - On rvalid && rready, go to CAPTURE; rvalid drops in CAPTURE.
  - Otherwise the counter increments each cycle.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without a handshake: pulse res_valid=1, res_err=1, res_data=0; increment txn_count; return to IDLE.
  - A handshake on the same cycle as the timeout wins; there is no error.
- CAPTURE: sample rdata (valid this cycle) into res_data; pulse res_valid for one cycle; increment txn_count; return to IDLE.
- res_data holds its value until the next result.
- Latency with no stalls, from cmd handshake cycle T:
  - op beat at T+1, a at T+2, b at T+3;
  - WAIT_RES at T+4, giving the earliest read handshake at T+4;
  - res_valid at T+5.
- A new command is accepted no earlier than the cycle after res_valid; cmd_valid is ignored while busy.
- txn_count wraps modulo 2^CNT_W.
- wready and rready are never combinationally fed to any output.

Test Plan:
- Basic op: cmd op=3'b001, a=8'h3C, b=8'h05, wready=1; FIFO model returns rdata=9'h041 -> wdata sequence 01,3C,05 on consecutive cycles; rvalid at T+4; res_valid at T+5 with res_data=9'h041; txn_count=1.
- Write backpressure: wready=0 for 4 cycles during the A beat -> wvalid held high and wdata=8'h3C stable for all 4 cycles; no duplicate or lost bytes; 3 write handshakes total.
- Read wait: rready=0 for 10 cycles in WAIT_RES -> rvalid held high; no res_valid until 1 cycle after the handshake; carry result rdata=9'h1FF -> res_data=9'h1FF.
- Timeout: TIMEOUT=8, rready tied 0 -> res_valid and res_err pulse together 8 cycles after WAIT_RES entry; res_data=0; state IDLE; txn_count increments.
- Reset mid-SEND_A: assert reset asynchronously between clock edges -> wvalid=0 and cmd_ready=1 immediately; no res_valid; the next command completes normally.
- Back-to-back commands: cmd_valid held high with 2 commands -> second accepted the cycle after the first res_valid; cmd_valid while busy is ignored; txn_count=2.

Source files
------------

// File: rtl/axi_alu_initiator.sv
// Initiator side of the byte-wide ALU FIFO channel pair: serialises one
// command as op/a/b write beats, then requests and returns the 9-bit result.
module axi_alu_initiator #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic [7:0]       wdata,
  output logic             wvalid,
  input  logic             wready,
  output logic             rvalid,
  input  logic             rready,
  input  logic [8:0]       rdata,
  output logic             res_valid,
  output logic [8:0]       res_data,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  // Last WAIT_RES count before the read is abandoned (unused when TIMEOUT is 0)
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_A,
    SEND_B,
    WAIT_RES,
    CAPTURE
  } state_t;

  state_t           state;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [8:0]       res_hold;

  // The FIFO presents rdata only during CAPTURE, which is also the res_valid
  // cycle, so it is forwarded there; res_hold keeps it afterwards.
  assign res_data = (state == CAPTURE) ? rdata : res_hold;

  // Command FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      tmo_cnt   <= '0;
      res_hold  <= 9'h000;
      cmd_ready <= 1'b1;
      wvalid    <= 1'b0;
      wdata     <= 8'h00;
      rvalid    <= 1'b0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      txn_count <= '0;
    end else begin
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            a_q       <= cmd_a;
            b_q       <= cmd_b;
            wdata     <= {5'b00000, cmd_op};
            wvalid    <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND_OP;
          end
        end
        SEND_OP: begin
          if (wready) begin
            wdata <= a_q;
            state <= SEND_A;
          end
        end
        SEND_A: begin
          if (wready) begin
            wdata <= b_q;
            state <= SEND_B;
          end
        end
        SEND_B: begin
          if (wready) begin
            wvalid  <= 1'b0;
            rvalid  <= 1'b1;
            tmo_cnt <= '0;
            state   <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (rvalid && rready) begin
            rvalid    <= 1'b0;
            res_valid <= 1'b1;
            txn_count <= txn_count + CNT_W'(1);
            state     <= CAPTURE;
          end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
            // Abandon the read; cmd_ready stays low through the error pulse
            rvalid    <= 1'b0;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_hold  <= 9'h000;
            txn_count <= txn_count + CNT_W'(1);
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          res_hold  <= rdata;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_alu_initiator.sv
// Bench for axi_alu_initiator: hand-built vector table, randomized
// transactions against a behavioural model, reset and back-to-back sequences.
module tb_axi_alu_initiator;

  localparam int unsigned TMO = 12;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic [7:0]    wdata;
  logic          wvalid;
  logic          wready;
  logic          rvalid;
  logic          rready;
  logic [8:0]    rdata;
  logic          res_valid;
  logic [8:0]    res_data;
  logic          res_err;
  logic          busy;
  logic [CW-1:0] txn_count;

  axi_alu_initiator #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read side: rdata is valid only in the cycle after a read handshake
  logic [8:0] rdata_pick = 9'h000;
  bit         rd_hs = 1'b0;
  always @(negedge clk) rd_hs <= rvalid && rready;
  always @(posedge clk) begin
    #1;
    rdata = rd_hs ? rdata_pick : 9'($urandom);
  end

  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] exp_txn  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] rd;
    int         ws_beat;
    int         ws_len;
    int         rs_len;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    logic [7:0] exp_b2;
    logic [8:0] exp_res;
    logic       exp_err;
    int         exp_rv;
    int         exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [8:0] rd, input int wsb, input int wsl, input int rsl,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [8:0] eres, input logic eerr, input int erv, input int elat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd;
    v.ws_beat = wsb; v.ws_len = wsl; v.rs_len = rsl;
    v.exp_b0 = e0; v.exp_b1 = e1; v.exp_b2 = e2;
    v.exp_res = eres; v.exp_err = eerr; v.exp_rv = erv; v.exp_lat = elat;
    return v;
  endfunction

  // Reference model: three bytes op/a/b; a read stall of TMO or more cycles
  // ends in an error after TMO cycles of waiting, otherwise the FIFO word
  // comes back one cycle after the read handshake.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_b0 = {5'b00000, v.op};
    r.exp_b1 = v.a;
    r.exp_b2 = v.b;
    r.exp_rv = 4 + v.ws_len;
    if (v.rs_len >= int'(TMO)) begin
      r.exp_err = 1'b1;
      r.exp_res = 9'h000;
      r.exp_lat = 4 + v.ws_len + int'(TMO);
    end else begin
      r.exp_err = 1'b0;
      r.exp_res = v.rd;
      r.exp_lat = 5 + v.ws_len + v.rs_len;
    end
    return r;
  endfunction

  // Drive one command with the requested stalls and compare against v
  task automatic run_txn(input string tag, input vec_t v);
    int         t0, t_wv, t_rv, t_res, nb, wst, rsl;
    logic [7:0] bytes [3];
    logic [7:0] held;
    bit         stalled, hold_ok, done;
    logic [8:0] got_data;
    logic       got_err;
    t0 = -1; t_wv = -1; t_rv = -1; t_res = -1; nb = 0; wst = 0; rsl = 0;
    held = 8'h00; stalled = 1'b0; hold_ok = 1'b1; done = 1'b0;
    got_data = 9'h000; got_err = 1'b0;
    for (int i = 0; i < 3; i++) bytes[i] = 8'h00;
    rdata_pick = v.rd;
    for (int cy = 0; cy < 200 && !done; cy++) begin
      @(posedge clk); #1;
      if (t0 < 0) begin
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
      end else begin
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      end
      if (wvalid && nb == v.ws_beat && wst < v.ws_len) begin
        wready = 1'b0; wst++;
      end else begin
        wready = 1'b1;
      end
      if (rvalid && rsl < v.rs_len) begin
        rready = 1'b0; rsl++;
      end else begin
        rready = 1'b1;
      end
      @(negedge clk);
      if (t0 < 0 && cmd_valid && cmd_ready) t0 = cyc;
      if (stalled && (!wvalid || wdata != held)) hold_ok = 1'b0;
      stalled = wvalid && !wready;
      held = wdata;
      if (wvalid && wready) begin
        if (nb < 3) bytes[nb] = wdata;
        nb++;
      end
      if (t0 >= 0 && t_wv < 0 && wvalid) t_wv = cyc - t0;
      if (t0 >= 0 && t_rv < 0 && rvalid) t_rv = cyc - t0;
      if (res_valid) begin
        t_res = cyc - t0; got_data = res_data; got_err = res_err; done = 1'b1;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_nbytes"}, nb, 3);
    check({tag, "_b0"}, bytes[0], v.exp_b0);
    check({tag, "_b1"}, bytes[1], v.exp_b1);
    check({tag, "_b2"}, bytes[2], v.exp_b2);
    check({tag, "_whold"}, 32'(hold_ok), 32'd1);
    check({tag, "_wv_lat"}, t_wv, 1);
    check({tag, "_rv_lat"}, t_rv, v.exp_rv);
    check({tag, "_res_lat"}, t_res, v.exp_lat);
    check({tag, "_res_data"}, got_data, v.exp_res);
    check({tag, "_res_err"}, 32'(got_err), 32'(v.exp_err));
    exp_txn++;
    @(posedge clk); #1;
    wready = 1'b1; rready = 1'b1;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(res_valid), 32'd0);
    check({tag, "_hold"}, res_data, v.exp_res);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_txn"}, txn_count, exp_txn);
  endtask

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    bit         got;
    int         quiet, hs_n, rs_n, t1, t2, r1;
    logic [8:0] d1, d2;

    tbl[0] = mk(3'd1, 8'h3C, 8'h05, 9'h041, 0, 0, 0,  8'h01, 8'h3C, 8'h05, 9'h041, 1'b0, 4, 5);
    tbl[1] = mk(3'd1, 8'h3C, 8'h05, 9'h0AA, 1, 4, 0,  8'h01, 8'h3C, 8'h05, 9'h0AA, 1'b0, 8, 9);
    tbl[2] = mk(3'd7, 8'hFF, 8'hFF, 9'h1FF, 0, 0, 10, 8'h07, 8'hFF, 8'hFF, 9'h1FF, 1'b0, 4, 15);
    tbl[3] = mk(3'd2, 8'h80, 8'h01, 9'h155, 0, 0, 11, 8'h02, 8'h80, 8'h01, 9'h155, 1'b0, 4, 16);
    tbl[4] = mk(3'd5, 8'h11, 8'h22, 9'h0AB, 0, 0, 12, 8'h05, 8'h11, 8'h22, 9'h000, 1'b1, 4, 16);
    tbl[5] = mk(3'd0, 8'h00, 8'h00, 9'h0F0, 2, 3, 20, 8'h00, 8'h00, 8'h00, 9'h000, 1'b1, 7, 19);
    tbl[6] = mk(3'd6, 8'h5A, 8'hA5, 9'h100, 0, 2, 3,  8'h06, 8'h5A, 8'hA5, 9'h100, 1'b0, 6, 10);

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    wready = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_wdata", wdata, 8'h00);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 9'h000);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txn", txn_count, 4'h0);

    for (int i = 0; i < 7; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

    // Asynchronous reset while the A beat is held off by wready
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'hC3; cmd_b = 8'h3C; wready = 1'b1; rready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = cmd_valid && cmd_ready;
      if (!got) begin @(posedge clk); #1; end
    end
    check("mrst_hs", 32'(got), 32'd1);
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1; wready = 1'b0;
    @(negedge clk);
    check("mrst_pre_wvalid", 32'(wvalid), 32'd1);
    check("mrst_pre_wdata", wdata, 8'hC3);
    #2; reset = 1'b1; #1;
    check("mrst_wvalid", 32'(wvalid), 32'd0);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_txn", txn_count, 4'h0);
    exp_txn = '0;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid || wvalid || rvalid || busy) quiet++;
    end
    check("mrst_quiet", quiet, 0);
    v.op = 3'd3; v.a = 8'h77; v.b = 8'h88; v.rd = 9'h077;
    v.ws_beat = 0; v.ws_len = 0; v.rs_len = 1;
    run_txn("mrst_next", model(v));

    // Back-to-back: cmd_valid held high across two commands
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'h10; cmd_b = 8'h20;
    wready = 1'b1; rready = 1'b1; rdata_pick = 9'h0C3;
    hs_n = 0; rs_n = 0; t1 = -1; t2 = -1; r1 = -1; d1 = 9'h000; d2 = 9'h000;
    for (int i = 0; i < 60 && rs_n < 2; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        hs_n++;
        if (hs_n == 1) t1 = cyc; else t2 = cyc;
      end
      if (res_valid) begin
        rs_n++;
        if (rs_n == 1) begin r1 = cyc; d1 = res_data; end else d2 = res_data;
      end
      @(posedge clk); #1;
      if (hs_n == 1) begin cmd_op = 3'd2; cmd_a = 8'h30; cmd_b = 8'h40; end
      if (hs_n >= 2) cmd_valid = 1'b0;
      if (rs_n >= 1) rdata_pick = 9'h13C;
    end
    cmd_valid = 1'b0;
    exp_txn = exp_txn + CW'(2);
    check("b2b_handshakes", hs_n, 2);
    check("b2b_first_lat", r1 - t1, 5);
    check("b2b_second_accept", t2 - r1, 1);
    check("b2b_res1", d1, 9'h0C3);
    check("b2b_res2", d2, 9'h13C);
    @(negedge clk);
    check("b2b_txn", txn_count, exp_txn);

    // Randomized transactions against the model (txn_count wraps in 4 bits)
    for (int i = 0; i < 40; i++) begin
      v.op = 3'($urandom); v.a = 8'($urandom); v.b = 8'($urandom); v.rd = 9'($urandom);
      v.ws_beat = $urandom_range(0, 2);
      v.ws_len  = $urandom_range(0, 3);
      v.rs_len  = $urandom_range(0, TMO + 2);
      run_txn($sformatf("rnd%0d", i), model(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
